// File: rtl/bgd_pixel_fetch_if.sv
// Raster-side and ROM-side signals of the background fetch stage.
// The slave side is the fetch stage itself; the master side is whatever
// drives the raster timing and hosts the background ROM.
interface bgd_pixel_fetch_if #(
  parameter int ADDR_W = 17
);
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic              vde;
  logic              vs;
  logic              scroll_en;
  logic [3:0]        scroll_speed;
  logic [ADDR_W-1:0] rom_addr;
  logic [3:0]        rom_q;
  logic [3:0]        pix_index;
  logic              pix_valid;
  logic [8:0]        scroll_off;

  modport master (
    output DrawX, DrawY, vde, vs, scroll_en, scroll_speed, rom_q,
    input  rom_addr, pix_index, pix_valid, scroll_off
  );

  modport slave (
    input  DrawX, DrawY, vde, vs, scroll_en, scroll_speed, rom_q,
    output rom_addr, pix_index, pix_valid, scroll_off
  );
endinterface

// File: rtl/bgd_pixel_fetch.sv
// Background pixel fetch: maps raster coordinates to a downscaled,
// horizontally scrolled 4bpp image ROM address and returns the palette
// index aligned to the raster with a fixed ROM_LAT+2 edge latency.
module bgd_pixel_fetch #(
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int SCALE_SHIFT = 1,
  parameter int ROM_LAT     = 1,
  parameter int ADDR_W      = 17
) (
  input  logic             Clk,
  input  logic             Reset,
  bgd_pixel_fetch_if.slave bus
);

  localparam logic [9:0]  IMG_W_10 = 10'(IMG_W);
  localparam logic [10:0] IMG_W_11 = 11'(IMG_W);
  localparam logic [10:0] IMG_H_11 = 11'(IMG_H);

  logic              vs_d;
  logic              tick;
  logic [8:0]        scroll;
  logic [9:0]        scroll_sum;
  logic [8:0]        scroll_next;
  logic [10:0]       xi;
  logic [10:0]       yi;
  logic [10:0]       xs_sum;
  logic [10:0]       xs;
  logic              in_rng;
  logic [ADDR_W-1:0] lin_addr;
  logic [ADDR_W-1:0] addr_a;
  logic [ROM_LAT:0]  vchain;
  logic [3:0]        index_b;
  logic              valid_b;

  // Frame tick, scroll wrap and coordinate-to-address mapping.
  always_comb begin
    tick        = vs_d & ~bus.vs;
    scroll_sum  = {1'b0, scroll} + {6'b0, bus.scroll_speed};
    scroll_next = 9'((scroll_sum >= IMG_W_10) ? scroll_sum - IMG_W_10 : scroll_sum);
    xi          = {1'b0, bus.DrawX >> SCALE_SHIFT};
    yi          = {1'b0, bus.DrawY >> SCALE_SHIFT};
    in_rng      = bus.vde && (xi < IMG_W_11) && (yi < IMG_H_11);
    xs_sum      = xi + {2'b0, scroll};
    xs          = (xs_sum >= IMG_W_11) ? xs_sum - IMG_W_11 : xs_sum;
    // Modular arithmetic in ADDR_W bits is exact: in-range addresses are
    // below IMG_W*IMG_H, which fits ADDR_W by construction.
    lin_addr    = ADDR_W'(yi) * ADDR_W'(IMG_W) + ADDR_W'(xs);
  end

  // vs history and scroll offset, advanced once per vs falling edge.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_d   <= 1'b1;
      scroll <= '0;
    end else begin
      vs_d <= bus.vs;
      if (tick && bus.scroll_en)
        scroll <= scroll_next;
    end
  end

  // Stage A address register and valid delay line matching ROM latency.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      addr_a <= '0;
      vchain <= '0;
    end else begin
      addr_a    <= in_rng ? lin_addr : '0;
      vchain[0] <= in_rng;
      for (int i = ROM_LAT; i > 0; i--)
        vchain[i] <= vchain[i-1];
    end
  end

  // Stage B: capture ROM data only for visible pixels, zero otherwise.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      index_b <= '0;
      valid_b <= 1'b0;
    end else begin
      index_b <= vchain[ROM_LAT] ? bus.rom_q : 4'h0;
      valid_b <= vchain[ROM_LAT];
    end
  end

  assign bus.rom_addr   = addr_a;
  assign bus.pix_index  = index_b;
  assign bus.pix_valid  = valid_b;
  assign bus.scroll_off = scroll;

endmodule
